// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Purpose  : Direct-mapped, one-word-per-line instruction cache between the
//            fetch stage and the memory-controller instruction port.
//            Hits are answered combinationally. A miss fills the line over a
//            request/wait handshake and then returns to lookup.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK         in   system clock, rising edge
//   nRST        in   asynchronous reset, active low
//   imemREN     in   fetch request this cycle
//   imemaddr    in   [31:0] byte address of the instruction (bits [1:0] unused)
//   ihit        out  imemload is valid for imemaddr this cycle
//   imemload    out  [31:0] instruction word to the fetch stage
//   flush       in   one-cycle pulse, invalidate every line
//   iREN        out  fill read request to the memory controller
//   iaddr       out  [31:0] word-aligned fill address
//   iwait       in   memory controller busy (data valid when low)
//   iload       in   [31:0] fill data
//   hit_count   out  [31:0] saturating count of ihit cycles
//   miss_count  out  [31:0] saturating count of misses
// ============================================================================
module icache_responder #(
  parameter int NSETS = 16,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tags [NSETS];
  logic [31:0]      data [NSETS];

  logic [31:0] miss_addr;
  logic        flush_pending;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             lookup_hit;
  logic             miss_start;
  logic             fill_done;

  // Byte-offset bits of the fetch address carry no information for a
  // word-organised cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^imemaddr[1:0];

  assign req_tag  = imemaddr[31:32-TAG_W];
  assign req_idx  = imemaddr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:32-TAG_W];
  assign fill_idx = miss_addr[IDX_W+1:2];

  assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data[req_idx];
          end else begin
            miss_start = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        // The fill runs to completion regardless of what the fetch stage
        // does meanwhile; the lookup afterwards uses the live address.
        if (!iwait) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Miss address and deferred flush
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr     <= 32'h0;
      flush_pending <= 1'b0;
    end else begin
      if (miss_start) begin
        miss_addr <= {imemaddr[31:2], 2'b00};
      end
      if (fill_done) begin
        flush_pending <= 1'b0;
      end else if ((state == FILL) && flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Valid bits. A flush seen during a fill (including on its last cycle)
  // also discards the line just written.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (fill_done) begin
      if (flush_pending || flush) begin
        valid <= '0;
      end else begin
        valid[fill_idx] <= 1'b1;
      end
    end else if ((state == IDLE) && flush) begin
      valid <= '0;
    end
  end

  // Tag and data storage needs no reset: valid gates every read.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_responder
// Purpose  : Directed self-checking bench for icache_responder (NSETS=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_icache_responder;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int errors = 0;
  int checks = 0;

  icache_responder #(.NSETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: 0x40 holds 0x2000_0005, every other word holds
  // {addr[15:0], 16'hC0DE}.
  always_comb begin
    if (iaddr == 32'h40) iload = 32'h2000_0005;
    else                 iload = {iaddr[15:0], 16'hC0DE};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a missing address, then serve the fill with lat wait cycles.
  // Returns one step after the completing edge, ready for a lookup.
  task automatic fetch_miss(input logic [31:0] addr, input int lat);
    imemREN  = 1'b1;
    imemaddr = addr;
    #1;
    chk("miss_ihit", {31'b0, ihit}, 32'h0);
    chk("miss_iren", {31'b0, iREN}, 32'h0);
    tick();
    for (int i = 0; i < lat; i++) begin
      chk("fill_iren", {31'b0, iREN}, 32'h1);
      chk("fill_iaddr", iaddr, addr);
      tick();
    end
    iwait = 1'b0;
    #1;
    chk("fill_last_iren", {31'b0, iREN}, 32'h1);
    chk("fill_last_iaddr", iaddr, addr);
    chk("fill_last_ihit", {31'b0, ihit}, 32'h0);
    tick();
    iwait = 1'b1;
  endtask

  task automatic pulse_reset();
    #1 nRST = 1'b0;
    #2 nRST = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    flush    = 1'b0;
    iwait    = 1'b1;
    #3;
    chk("rst_ihit", {31'b0, ihit}, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_hits", hit_count, 32'h0);
    chk("rst_misses", miss_count, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // ---- 1: cold miss, 3 wait cycles, then hit ----
    fetch_miss(32'h40, 3);
    #1;
    chk("t1_ihit", {31'b0, ihit}, 32'h1);
    chk("t1_load", imemload, 32'h2000_0005);
    chk("t1_iren", {31'b0, iREN}, 32'h0);
    chk("t1_misses", miss_count, 32'd1);
    tick();
    imemREN = 1'b0;
    #1;
    chk("t1_idle_ihit", {31'b0, ihit}, 32'h0);
    chk("t1_idle_load", imemload, 32'h0);
    chk("t1_hits", hit_count, 32'd1);

    // ---- 2: preload 0x0/0x4/0x8 then consecutive hits ----
    fetch_miss(32'h0, 0);
    fetch_miss(32'h4, 1);
    fetch_miss(32'h8, 0);
    imemaddr = 32'h0;
    #1;
    chk("t2_hit0", {31'b0, ihit}, 32'h1);
    chk("t2_load0", imemload, 32'h0000_C0DE);
    chk("t2_iren0", {31'b0, iREN}, 32'h0);
    tick();
    imemaddr = 32'h4;
    #1;
    chk("t2_hit4", {31'b0, ihit}, 32'h1);
    chk("t2_load4", imemload, 32'h0004_C0DE);
    chk("t2_iren4", {31'b0, iREN}, 32'h0);
    tick();
    imemaddr = 32'h8;
    #1;
    chk("t2_hit8", {31'b0, ihit}, 32'h1);
    chk("t2_load8", imemload, 32'h0008_C0DE);
    chk("t2_iren8", {31'b0, iREN}, 32'h0);
    tick();
    imemREN = 1'b0;
    #1;
    chk("t2_hits", hit_count, 32'd4);
    chk("t2_misses", miss_count, 32'd4);

    // ---- 3: conflict on idx 0 ----
    pulse_reset();
    chk("t3_rst_misses", miss_count, 32'd0);
    fetch_miss(32'h0, 1);
    fetch_miss(32'h40, 1);
    fetch_miss(32'h0, 1);
    #1;
    chk("t3_misses", miss_count, 32'd3);
    chk("t3_hit", {31'b0, ihit}, 32'h1);
    chk("t3_load", imemload, 32'h0000_C0DE);

    // ---- 4a: flush in IDLE ----
    fetch_miss(32'h10, 0);
    flush = 1'b1;
    #1;
    chk("t4_preflush_hit", {31'b0, ihit}, 32'h1);
    chk("t4_preflush_load", imemload, 32'h0010_C0DE);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_postflush_ihit", {31'b0, ihit}, 32'h0);
    fetch_miss(32'h10, 0);
    #1;
    chk("t4_refill_hit", {31'b0, ihit}, 32'h1);
    // The idx-0 line was also flushed.
    imemaddr = 32'h0;
    #1;
    chk("t4_other_line_gone", {31'b0, ihit}, 32'h0);

    // ---- 4b: flush during FILL ----
    imemaddr = 32'h20;
    #1;
    chk("t4b_miss", {31'b0, ihit}, 32'h0);
    tick();
    chk("t4b_fill", {31'b0, iREN}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4b_still_fill", {31'b0, iREN}, 32'h1);
    iwait = 1'b0;
    tick();
    iwait = 1'b1;
    #1;
    chk("t4b_after_fill_iren", {31'b0, iREN}, 32'h0);
    chk("t4b_after_fill_ihit", {31'b0, ihit}, 32'h0);
    fetch_miss(32'h20, 0);
    #1;
    chk("t4b_refill_hit", {31'b0, ihit}, 32'h1);
    chk("t4b_refill_load", imemload, 32'h0020_C0DE);

    // ---- 5: address change during fill ----
    imemaddr = 32'h100;
    #1;
    chk("t5_miss", {31'b0, ihit}, 32'h0);
    tick();
    imemaddr = 32'h104;
    #1;
    chk("t5_iaddr_a", iaddr, 32'h100);
    tick();
    chk("t5_iaddr_b", iaddr, 32'h100);
    iwait = 1'b0;
    tick();
    iwait = 1'b1;
    #1;
    chk("t5_104_miss", {31'b0, ihit}, 32'h0);
    tick();
    chk("t5_new_iren", {31'b0, iREN}, 32'h1);
    chk("t5_new_iaddr", iaddr, 32'h104);
    iwait = 1'b0;
    tick();
    iwait = 1'b1;
    #1;
    chk("t5_104_hit", {31'b0, ihit}, 32'h1);
    chk("t5_104_load", imemload, 32'h0104_C0DE);
    imemaddr = 32'h100;
    #1;
    chk("t5_100_hit", {31'b0, ihit}, 32'h1);
    chk("t5_100_load", imemload, 32'h0100_C0DE);

    // ---- 6: async reset mid-fill ----
    imemaddr = 32'h200;
    #1;
    chk("t6_miss", {31'b0, ihit}, 32'h0);
    tick();
    #1;
    chk("t6_in_fill", {31'b0, iREN}, 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_iren", {31'b0, iREN}, 32'h0);
    chk("t6_rst_ihit", {31'b0, ihit}, 32'h0);
    chk("t6_rst_iaddr", iaddr, 32'h0);
    chk("t6_rst_hits", hit_count, 32'h0);
    chk("t6_rst_misses", miss_count, 32'h0);
    #2 nRST = 1'b1;
    imemaddr = 32'h100;
    #1;
    chk("t6_100_miss", {31'b0, ihit}, 32'h0);
    fetch_miss(32'h100, 0);
    #1;
    chk("t6_100_hit", {31'b0, ihit}, 32'h1);
    chk("t6_misses", miss_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
